// File: rtl/uart_sys_ctrl_if.sv
// Bus bundle between the UART command controller and its RX, register-file, ALU and TX FIFO peers.
// master = controller side, slave = peripheral/environment side.
interface uart_sys_ctrl_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4,
   parameter int FUN_WIDTH  = 4
);
   logic [DATA_WIDTH-1:0]   RX_P_DATA;
   logic                    RX_D_VLD;
   logic [DATA_WIDTH-1:0]   RdData;
   logic                    RdData_Valid;
   logic [2*DATA_WIDTH-1:0] ALU_OUT;
   logic                    ALU_OUT_VLD;
   logic                    FIFO_FULL;
   logic                    WrEn;
   logic                    RdEn;
   logic [ADDR_WIDTH-1:0]   Address;
   logic [DATA_WIDTH-1:0]   WrData;
   logic                    ALU_EN;
   logic [FUN_WIDTH-1:0]    ALU_FUN;
   logic                    CLK_GATE_EN;
   logic [DATA_WIDTH-1:0]   TX_P_DATA;
   logic                    TX_D_VLD;

   modport master (
      input  RX_P_DATA, RX_D_VLD, RdData, RdData_Valid, ALU_OUT, ALU_OUT_VLD, FIFO_FULL,
      output WrEn, RdEn, Address, WrData, ALU_EN, ALU_FUN, CLK_GATE_EN, TX_P_DATA, TX_D_VLD
   );

   modport slave (
      output RX_P_DATA, RX_D_VLD, RdData, RdData_Valid, ALU_OUT, ALU_OUT_VLD, FIFO_FULL,
      input  WrEn, RdEn, Address, WrData, ALU_EN, ALU_FUN, CLK_GATE_EN, TX_P_DATA, TX_D_VLD
   );
endinterface

// File: rtl/uart_sys_ctrl.sv
// UART command controller: decodes received byte frames into register-file and ALU operations
// and streams result bytes into the TX FIFO under FIFO_FULL backpressure.
module uart_sys_ctrl #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4,
   parameter int FUN_WIDTH  = 4
) (
   input  logic               CLK,
   input  logic               RST,
   uart_sys_ctrl_if.master    bus
);

   localparam logic [DATA_WIDTH-1:0] CMD_WR     = DATA_WIDTH'(8'hAA);
   localparam logic [DATA_WIDTH-1:0] CMD_RD     = DATA_WIDTH'(8'hBB);
   localparam logic [DATA_WIDTH-1:0] CMD_ALU_OP = DATA_WIDTH'(8'hCC);
   localparam logic [DATA_WIDTH-1:0] CMD_ALU_NO = DATA_WIDTH'(8'hDD);

   typedef enum logic [3:0] {
      IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, RD_TX,
      ALU_A, ALU_B, ALU_FUN, ALU_WAIT, TX_LO, TX_HI
   } state_t;

   state_t                  state;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [2*DATA_WIDTH-1:0] result_q;
   logic [DATA_WIDTH-1:0]   rd_byte_q;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state     <= IDLE;
         addr_q    <= '0;
         result_q  <= '0;
         rd_byte_q <= '0;
      end else begin
         case (state)
            IDLE: if (bus.RX_D_VLD) begin
               case (bus.RX_P_DATA)
                  CMD_WR:     state <= WR_ADDR;
                  CMD_RD:     state <= RD_ADDR;
                  CMD_ALU_OP: state <= ALU_A;
                  CMD_ALU_NO: state <= ALU_FUN;
                  default:    state <= IDLE;
               endcase
            end
            WR_ADDR: if (bus.RX_D_VLD) begin
               addr_q <= bus.RX_P_DATA[ADDR_WIDTH-1:0];
               state  <= WR_DATA;
            end
            WR_DATA: if (bus.RX_D_VLD) state <= IDLE;
            RD_ADDR: if (bus.RX_D_VLD) state <= RD_WAIT;
            RD_WAIT: if (bus.RdData_Valid) begin
               rd_byte_q <= bus.RdData;
               state     <= RD_TX;
            end
            RD_TX:   if (!bus.FIFO_FULL) state <= IDLE;
            ALU_A:   if (bus.RX_D_VLD) state <= ALU_B;
            ALU_B:   if (bus.RX_D_VLD) state <= ALU_FUN;
            ALU_FUN: if (bus.RX_D_VLD) state <= ALU_WAIT;
            ALU_WAIT: if (bus.ALU_OUT_VLD) begin
               result_q <= bus.ALU_OUT;
               state    <= TX_LO;
            end
            TX_LO:   if (!bus.FIFO_FULL) state <= TX_HI;
            TX_HI:   if (!bus.FIFO_FULL) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Strobes are decoded combinationally so they coincide with the accepting RX_D_VLD cycle.
   always_comb begin
      bus.WrEn        = 1'b0;
      bus.RdEn        = 1'b0;
      bus.Address     = '0;
      bus.WrData      = '0;
      bus.ALU_EN      = 1'b0;
      bus.ALU_FUN     = '0;
      bus.CLK_GATE_EN = 1'b0;
      bus.TX_P_DATA   = '0;
      bus.TX_D_VLD    = 1'b0;
      case (state)
         WR_DATA: if (bus.RX_D_VLD) begin
            bus.WrEn    = 1'b1;
            bus.Address = addr_q;
            bus.WrData  = bus.RX_P_DATA;
         end
         RD_ADDR: if (bus.RX_D_VLD) begin
            bus.RdEn    = 1'b1;
            bus.Address = bus.RX_P_DATA[ADDR_WIDTH-1:0];
         end
         ALU_A: if (bus.RX_D_VLD) begin
            bus.WrEn    = 1'b1;
            bus.Address = ADDR_WIDTH'(0);
            bus.WrData  = bus.RX_P_DATA;
         end
         ALU_B: if (bus.RX_D_VLD) begin
            bus.WrEn    = 1'b1;
            bus.Address = ADDR_WIDTH'(1);
            bus.WrData  = bus.RX_P_DATA;
         end
         ALU_FUN: begin
            bus.CLK_GATE_EN = 1'b1;
            if (bus.RX_D_VLD) begin
               bus.ALU_EN  = 1'b1;
               bus.ALU_FUN = bus.RX_P_DATA[FUN_WIDTH-1:0];
            end
         end
         ALU_WAIT: bus.CLK_GATE_EN = 1'b1;
         RD_TX: begin
            bus.TX_P_DATA = rd_byte_q;
            bus.TX_D_VLD  = !bus.FIFO_FULL;
         end
         TX_LO: begin
            bus.CLK_GATE_EN = 1'b1;
            bus.TX_P_DATA   = result_q[DATA_WIDTH-1:0];
            bus.TX_D_VLD    = !bus.FIFO_FULL;
         end
         TX_HI: begin
            bus.CLK_GATE_EN = 1'b1;
            bus.TX_P_DATA   = result_q[2*DATA_WIDTH-1:DATA_WIDTH];
            bus.TX_D_VLD    = !bus.FIFO_FULL;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_uart_sys_ctrl.sv
// Scoreboard bench for uart_sys_ctrl: emulates register file, ALU and TX FIFO, and compares
// observed strobes/TX bytes against expectations derived from a frame-level model.
module tb_uart_sys_ctrl;
   localparam int DW = 8;
   localparam int AW = 4;
   localparam int FW = 4;

   logic CLK = 1'b0;
   logic RST;
   always #5 CLK = ~CLK;

   uart_sys_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FUN_WIDTH(FW)) bus();
   uart_sys_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FUN_WIDTH(FW)) dut (
      .CLK(CLK), .RST(RST), .bus(bus)
   );

   int checks = 0;
   int errors = 0;

   logic [AW+DW-1:0] wr_q[$];
   logic [AW-1:0]    rd_q[$];
   logic [FW-1:0]    alu_q[$];
   logic [DW-1:0]    tx_q[$];
   logic [DW-1:0]    model_mem[16];
   logic [DW-1:0]    rf[16];

   logic            rand_full = 1'b0;
   int              rd_cnt = -1;
   int              alu_cnt = -1;
   logic [AW-1:0]   rd_a;
   logic [FW-1:0]   alu_f_q;
   int              alu_tx_left = 0;
   logic            alu_fired = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s: event with no expectation pending", name);
   endtask

   // ALU behaviour emulated by the bench; function 0 is multiply.
   function automatic logic [2*DW-1:0] alu_f(input logic [DW-1:0] a, b, input logic [FW-1:0] f);
      case (f)
         0:       return 16'(a) * 16'(b);
         1:       return 16'(a) + 16'(b);
         2:       return 16'(a) - 16'(b);
         3:       return {8'h00, a & b};
         default: return {a ^ b, ~b};
      endcase
   endfunction

   // Monitor / scoreboard
   always @(negedge CLK) begin
      if (RST === 1'b1) begin
         chk("tx_while_full", 32'(bus.TX_D_VLD & bus.FIFO_FULL), 0);
         chk("gate_on_strobe", 32'((bus.WrEn | bus.RdEn) & bus.CLK_GATE_EN), 0);
         if (alu_tx_left > 0) chk("gate_busy", 32'(bus.CLK_GATE_EN), 1);
         if (!bus.WrEn && !bus.RdEn) chk("addr_idle", 32'({bus.Address, bus.WrData}), 0);
         if (!bus.ALU_EN) chk("fun_idle", 32'(bus.ALU_FUN), 0);
         if (bus.WrEn) begin
            if (wr_q.size() == 0) fail("wr_unexpected");
            else chk("wr", 32'({bus.Address, bus.WrData}), 32'(wr_q.pop_front()));
            rf[bus.Address] = bus.WrData;
         end
         if (bus.RdEn) begin
            if (rd_q.size() == 0) fail("rd_unexpected");
            else chk("rd_addr", 32'(bus.Address), 32'(rd_q.pop_front()));
            rd_a   = bus.Address;
            rd_cnt = $urandom_range(1, 4);
         end
         if (bus.ALU_EN) begin
            chk("gate_en", 32'(bus.CLK_GATE_EN), 1);
            if (alu_q.size() == 0) fail("alu_unexpected");
            else chk("alu_fun", 32'(bus.ALU_FUN), 32'(alu_q.pop_front()));
            alu_f_q     = bus.ALU_FUN;
            alu_cnt     = $urandom_range(1, 4);
            alu_tx_left = 2;
         end
         if (bus.TX_D_VLD) begin
            if (tx_q.size() == 0) fail("tx_unexpected");
            else chk("tx_data", 32'(bus.TX_P_DATA), 32'(tx_q.pop_front()));
            if (alu_tx_left > 0) alu_tx_left--;
         end
      end
   end

   // Register-file and ALU responders
   always @(posedge CLK) begin
      #1;
      bus.RdData_Valid = 1'b0;
      bus.ALU_OUT_VLD  = 1'b0;
      if (rd_cnt == 0) begin
         bus.RdData_Valid = 1'b1;
         bus.RdData       = rf[rd_a];
         rd_cnt           = -1;
      end else if (rd_cnt > 0) rd_cnt--;
      if (alu_cnt == 0) begin
         bus.ALU_OUT_VLD = 1'b1;
         bus.ALU_OUT     = alu_f(rf[0], rf[1], alu_f_q);
         alu_cnt         = -1;
         alu_fired       = 1'b1;
      end else if (alu_cnt > 0) alu_cnt--;
   end

   always @(posedge CLK) begin
      #1;
      if (rand_full) bus.FIFO_FULL = ($urandom_range(0, 3) == 0);
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   // Called just after a rising edge; leaves the bench just after a rising edge.
   task automatic send_byte(input logic [DW-1:0] b, input int gap);
      bus.RX_P_DATA = b;
      bus.RX_D_VLD  = 1'b1;
      @(posedge CLK); #1;
      bus.RX_D_VLD  = 1'b0;
      bus.RX_P_DATA = '0;
      repeat (gap) begin @(posedge CLK); #1; end
   endtask

   function automatic int rgap();
      return $urandom_range(0, 2);
   endfunction

   task automatic send_junk(input logic en);
      if (en) send_byte(DW'($urandom), rgap());
   endtask

   task automatic frame_wr(input logic [DW-1:0] a, input logic [DW-1:0] d);
      wr_q.push_back({a[AW-1:0], d});
      model_mem[a[AW-1:0]] = d;
      send_byte(8'hAA, rgap());
      send_byte(a, rgap());
      send_byte(d, rgap());
   endtask

   task automatic frame_rd(input logic [DW-1:0] a, input logic junk);
      rd_q.push_back(a[AW-1:0]);
      tx_q.push_back(model_mem[a[AW-1:0]]);
      send_byte(8'hBB, rgap());
      send_byte(a, 0);
      send_junk(junk);
   endtask

   task automatic push_alu(input logic [FW-1:0] f);
      logic [2*DW-1:0] r;
      alu_q.push_back(f);
      r = alu_f(model_mem[0], model_mem[1], f);
      tx_q.push_back(r[DW-1:0]);
      tx_q.push_back(r[2*DW-1:DW]);
   endtask

   task automatic frame_cc(input logic [DW-1:0] a, b, f, input logic junk);
      wr_q.push_back({AW'(0), a});
      wr_q.push_back({AW'(1), b});
      model_mem[0] = a;
      model_mem[1] = b;
      push_alu(f[FW-1:0]);
      send_byte(8'hCC, rgap());
      send_byte(a, rgap());
      send_byte(b, rgap());
      send_byte(f, 0);
      send_junk(junk);
   endtask

   task automatic frame_dd(input logic [DW-1:0] f, input logic junk);
      push_alu(f[FW-1:0]);
      send_byte(8'hDD, rgap());
      send_byte(f, 0);
      send_junk(junk);
   endtask

   task automatic wait_drain();
      int n = 0;
      while ((wr_q.size() + rd_q.size() + alu_q.size() + tx_q.size()) != 0 && n < 300) begin
         @(posedge CLK); #1;
         n++;
      end
      chk("drain_timeout", 32'(n < 300), 1);
      repeat (2) begin @(posedge CLK); #1; end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_WrEn"},      32'(bus.WrEn), 0);
      chk({tag, "_RdEn"},      32'(bus.RdEn), 0);
      chk({tag, "_Address"},   32'(bus.Address), 0);
      chk({tag, "_WrData"},    32'(bus.WrData), 0);
      chk({tag, "_ALU_EN"},    32'(bus.ALU_EN), 0);
      chk({tag, "_ALU_FUN"},   32'(bus.ALU_FUN), 0);
      chk({tag, "_GATE"},      32'(bus.CLK_GATE_EN), 0);
      chk({tag, "_TX_P_DATA"}, 32'(bus.TX_P_DATA), 0);
      chk({tag, "_TX_D_VLD"},  32'(bus.TX_D_VLD), 0);
   endtask

   initial begin
      int n;
      logic [DW-1:0] b;
      RST = 1'b0;
      bus.RX_P_DATA = '0;
      bus.RX_D_VLD  = 1'b0;
      bus.RdData    = '0;
      bus.ALU_OUT   = '0;
      bus.FIFO_FULL = 1'b0;
      for (int i = 0; i < 16; i++) begin
         model_mem[i] = '0;
         rf[i]        = '0;
      end
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      chk_all_zero("reset");
      @(posedge CLK); #1;
      RST = 1'b1;
      @(posedge CLK); #1;

      frame_wr(8'h05, 8'h3C);
      wait_drain();
      frame_rd(8'h07, 1'b0);
      wait_drain();
      frame_rd(8'h05, 1'b1);
      wait_drain();
      frame_cc(8'h03, 8'h04, 8'h00, 1'b1);
      wait_drain();

      // Result arrives while the FIFO is full and stays full for 5 more cycles.
      bus.FIFO_FULL = 1'b1;
      alu_fired = 1'b0;
      frame_dd(8'h02, 1'b0);
      n = 0;
      while (!alu_fired && n < 50) begin @(posedge CLK); #1; n++; end
      chk("alu_result_seen", 32'(alu_fired), 1);
      repeat (5) begin @(posedge CLK); #1; end
      chk("stall_pending_bytes", 32'(tx_q.size()), 2);
      bus.FIFO_FULL = 1'b0;
      wait_drain();

      send_byte(8'h11, 1);
      frame_wr(8'h01, 8'hFF);
      wait_drain();

      // Reset mid-frame after CC,03: A already written to reg 0.
      wr_q.push_back({AW'(0), 8'h03});
      model_mem[0] = 8'h03;
      send_byte(8'hCC, 0);
      send_byte(8'h03, 0);
      RST = 1'b0;
      @(negedge CLK);
      chk_all_zero("midrst");
      chk("midrst_wr_done", 32'(wr_q.size()), 0);
      @(posedge CLK); #1;
      RST = 1'b1;
      @(posedge CLK); #1;
      frame_wr(8'h0A, 8'h5E);
      frame_rd(8'h0A, 1'b0);
      wait_drain();

      rand_full = 1'b1;
      for (int i = 0; i < 60; i++) begin
         case ($urandom_range(0, 4))
            0: frame_wr(DW'($urandom), DW'($urandom));
            1: frame_rd(DW'($urandom), 1'($urandom));
            2: frame_cc(DW'($urandom), DW'($urandom), DW'($urandom_range(0, 7)), 1'($urandom));
            3: frame_dd(DW'($urandom_range(0, 7)), 1'($urandom));
            default: begin
               b = DW'($urandom);
               if (b == 8'hAA || b == 8'hBB || b == 8'hCC || b == 8'hDD) b = 8'h00;
               send_byte(b, rgap());
               frame_wr(DW'($urandom), DW'($urandom));
            end
         endcase
         wait_drain();
      end
      rand_full = 1'b0;
      @(posedge CLK); #1;
      bus.FIFO_FULL = 1'b0;
      repeat (4) begin @(posedge CLK); #1; end
      chk("final_queues_empty", 32'(wr_q.size() + rd_q.size() + alu_q.size() + tx_q.size()), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
